imm_pack: RTL

- Instruction packer for the 16-bit ISA. Word format is {opcode[3:0], one[3:0], two[3:0], three[3:0]}.
- Performs the inverse of the ID-stage immediate extension: takes an opcode, register fields and a 16-bit immediate, and writes the immediate into the type's immediate fields.
- Checks that the immediate fits the field as a two's-complement value.
- Emits packed words with sequential write addresses through a 2-entry output buffer. Sits in the boot/program loader path ahead of instruction memory.

---
 rtl/imm_pack.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imm_pack.sv
// Instruction packer: folds a signed immediate into the type's immediate fields,
// range-checks it, and emits address-tagged words through a 2-entry output FIFO.
module imm_pack #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_one,
  input  logic [3:0]        in_two,
  input  logic [3:0]        in_three,
  input  logic [15:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_seen
);

  localparam int EW = 16 + ADDR_W + 1;

  logic [1:0]        r_cnt;
  logic [EW-1:0]     r_ent0;
  logic [EW-1:0]     r_ent1;
  logic              r_in_rdy;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_seen;

  logic [15:0]       w_instr;
  logic              w_err;
  logic [ADDR_W-1:0] w_tag;
  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_new;
  logic [1:0]        w_cnt_nxt;
  logic [EW-1:0]     w_ent0_nxt;
  logic [EW-1:0]     w_ent1_nxt;

  // Immediate placement and two's-complement fit check by instruction type
  always_comb begin
    w_instr = {in_opcode, in_one, in_two, in_three};
    w_err   = 1'b0;
    case (in_opcode)
      4'b1000, 4'b1011: begin
        w_instr = {in_opcode, in_one, in_two, in_imm[3:0]};
        w_err   = (in_imm[15:4] != {12{in_imm[3]}});
      end
      4'b0100, 4'b0101, 4'b0110: begin
        w_instr = {in_opcode, in_one, in_imm[7:0]};
        w_err   = (in_imm[15:8] != {8{in_imm[7]}});
      end
      4'b1100, 4'b1111: begin
        w_instr = {in_opcode, in_imm[11:0]};
        w_err   = (in_imm[15:12] != {4{in_imm[11]}});
      end
      default: begin
        w_instr = {in_opcode, in_one, in_two, in_three};
        w_err   = 1'b0;
      end
    endcase
  end

  assign w_push    = in_valid && r_in_rdy;
  assign w_pop     = (r_cnt != 2'd0) && out_ready;
  assign w_tag     = addr_load ? load_addr : r_addr;
  assign w_new     = {w_instr, w_tag, w_err};

  assign in_ready  = r_in_rdy;
  assign out_valid = (r_cnt != 2'd0);
  assign {out_instr, out_addr, out_err} = r_ent0;
  assign err_seen  = r_err_seen;

  // FIFO next state; entry 0 is always the head, so outputs come straight from flops
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_ent0_nxt = r_ent0;
    w_ent1_nxt = r_ent1;
    case (r_cnt)
      2'd0: begin
        if (w_push) begin
          w_ent0_nxt = w_new;
          w_cnt_nxt  = 2'd1;
        end else begin
          w_cnt_nxt  = 2'd0;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_ent0_nxt = w_new;
        end else if (w_push) begin
          w_ent1_nxt = w_new;
          w_cnt_nxt  = 2'd2;
        end else if (w_pop) begin
          w_cnt_nxt  = 2'd0;
        end else begin
          w_cnt_nxt  = 2'd1;
        end
      end
      2'd2: begin
        if (w_pop) begin
          w_ent0_nxt = r_ent1;
          w_cnt_nxt  = 2'd1;
        end else begin
          w_cnt_nxt  = 2'd2;
        end
      end
      default: begin
        w_cnt_nxt = 2'd0;
      end
    endcase
  end

  // State registers; in_ready is registered so it stays low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      r_ent0     <= {EW{1'b0}};
      r_ent1     <= {EW{1'b0}};
      r_in_rdy   <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_err_seen <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_ent0     <= w_ent0_nxt;
      r_ent1     <= w_ent1_nxt;
      r_in_rdy   <= (w_cnt_nxt != 2'd2);
      r_err_seen <= r_err_seen | (w_pop & r_ent0[0]);
      if (w_push) begin
        r_addr <= w_tag + ADDR_W'(1);
      end else if (addr_load) begin
        r_addr <= load_addr;
      end else begin
        r_addr <= r_addr;
      end
    end
  end

endmodule
